wavegen_stream: RTL and testbench
=================================

WAVEGEN_STREAM -- requirements
Module: wavegen_stream

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width (signed).
REQ-002 SHALL have parameter AMP_WIDTH, default 8, amplitude width (signed).
REQ-003 SHALL have parameter LUT_ADDR, default 6, phase address width, N = 2^LUT_ADDR points per period; legal range 3..DATA_WIDTH-2.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 conf_i  input  1  load-configuration strobe.
REQ-007 en_i  input  1  generation enable; low = pause.
REQ-008 amp_i  input  AMP_WIDTH  signed amplitude.
REQ-009 sel_i  input  2  waveform: 0 sine, 1 cosine, 2 triangle, 3 square.
REQ-010 step_i  input  LUT_ADDR  phase increment per sample.
REQ-011 len_i  input  16  samples per burst; 0 = continuous.
REQ-012 full_i  input  1  downstream FIFO full.
REQ-013 wr_en_o  output  1  FIFO write strobe, one per sample.
REQ-014 data_o  output  DATA_WIDTH  signed sample.
REQ-015 busy_o  output  1  high when state is not IDLE.
REQ-016 done_o  output  1  one-cycle pulse at burst completion.

Function
REQ-017 SHALL implement FSM IDLE, CONFI, GEN; conf_i in IDLE or GEN -> CONFI next cycle.
REQ-018 On entry to CONFI SHALL latch amp_i, sel_i, step_i, len_i; in CONFI SHALL clear phase addr and sample count, then go to GEN unconditionally.
REQ-019 conf_i in GEN SHALL abort the burst without done_o and restart via CONFI; conf_i in CONFI ignored.
REQ-020 In GEN, advance = en_i && !full_i && !conf_i; on advance: wr_en_o<=1, data_o<=scale(wave(addr)), addr<=(addr+step) mod N, count<=count+1.
REQ-021 In GEN without advance: wr_en_o<=0, data_o, addr, count held (no sample lost or duplicated).
REQ-022 Latency: one cycle from advancing edge to wr_en_o/data_o valid.
REQ-023 len!=0 and advance with count==len-1: go to IDLE; done_o=1 in the cycle wr_en_o shows the last sample.
REQ-024 Sine: ROM value round((2^(DATA_WIDTH-1)-1)*sin(2*pi*a/N)); cosine: sine ROM at (a+N/4) mod N.
REQ-025 Triangle: a<N/2 -> -2^(DATA_WIDTH-1)+a*2^(DATA_WIDTH-LUT_ADDR+1); else 2^(DATA_WIDTH-1)-1-(a-N/2)*2^(DATA_WIDTH-LUT_ADDR+1).
REQ-026 Square: a<N/2 -> 2^(DATA_WIDTH-1)-1; else -(2^(DATA_WIDTH-1)-1).
REQ-027 scale(w) = (w*amp) full-precision signed product, arithmetic shift right by AMP_WIDTH-1 (floor), reduced to DATA_WIDTH per REQ-032.
REQ-028 In IDLE and CONFI: wr_en_o=0, data_o holds last value.

Reset
REQ-029 rst SHALL immediately force state IDLE, addr 0, count 0, config registers 0.
REQ-030 During/after rst: data_o=0, wr_en_o=0, busy_o=0, done_o=0; reset mid-burst discards burst, no done_o.

Configuration
REQ-031 Macro WAVEGEN_SATURATE_EN selects output reduction.
REQ-032 Defined: shifted product clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; undefined: low DATA_WIDTH bits kept (two's-complement wrap).

Verification (default parameters)
REQ-033 conf amp=127, sine, step=16, len=4, en=1, full=0 -> data_o 0, 32511, 0, -32512 on 4 consecutive wr_en_o; done_o with 4th; busy_o low next cycle.
REQ-034 Square amp=-128, step=32, len=2 -> data_o -32767 then 32767; done_o once.
REQ-035 Triangle amp=-128, step=1, len=1 (a=0, product 32768) -> data_o 32767 with WAVEGEN_SATURATE_EN, -32768 without.
REQ-036 len=0, sine, step=1, amp=127; full_i high 3 cycles after 10th sample -> wr_en_o 0 for 3 cycles, 11th sample equals wave(a=10); sample 65 equals sample 1 (0); no done_o.
REQ-037 Cosine step=1, conf_i pulsed in GEN after 5 samples -> no done_o, CONFI one cycle, next sample 32511 (a=0).
REQ-038 rst asserted mid-burst -> same-cycle data_o=0, wr_en_o=0, busy_o=0; no output until new conf_i.

Source files
------------

// File: rtl/wavegen_stream_if.sv
// ---------------------------------------------------------------------------
// wavegen_stream_if
// Bundles the configuration, flow-control and sample-stream signals of the
// wavegen_stream waveform generator.
//   master : the controller/FIFO side (drives conf/en/amp/sel/step/len/full,
//            observes wr_en/data/busy/done)
//   slave  : the generator side (the wavegen_stream block itself)
// Signals:
//   conf_i   load-configuration strobe
//   en_i     generation enable (low = pause)
//   amp_i    signed amplitude, AMP_WIDTH bits
//   sel_i    waveform: 0 sine, 1 cosine, 2 triangle, 3 square
//   step_i   phase increment per sample, LUT_ADDR bits
//   len_i    samples per burst, 0 = continuous
//   full_i   downstream FIFO full
//   wr_en_o  FIFO write strobe, one per sample
//   data_o   signed sample, DATA_WIDTH bits
//   busy_o   generator not idle
//   done_o   one-cycle pulse with the last sample of a burst
// ---------------------------------------------------------------------------
interface wavegen_stream_if #(
    parameter int DATA_WIDTH = 16,
    parameter int AMP_WIDTH  = 8,
    parameter int LUT_ADDR   = 6
);
    logic                         conf_i;
    logic                         en_i;
    logic signed [AMP_WIDTH-1:0]  amp_i;
    logic        [1:0]            sel_i;
    logic        [LUT_ADDR-1:0]   step_i;
    logic        [15:0]           len_i;
    logic                         full_i;
    logic                         wr_en_o;
    logic signed [DATA_WIDTH-1:0] data_o;
    logic                         busy_o;
    logic                         done_o;

    modport master (
        output conf_i, en_i, amp_i, sel_i, step_i, len_i, full_i,
        input  wr_en_o, data_o, busy_o, done_o
    );

    modport slave (
        input  conf_i, en_i, amp_i, sel_i, step_i, len_i, full_i,
        output wr_en_o, data_o, busy_o, done_o
    );
endinterface

// File: rtl/wavegen_stream.sv
// ---------------------------------------------------------------------------
// wavegen_stream
// Streaming waveform generator. A configuration strobe latches amplitude,
// waveform shape, phase step and burst length; the generator then walks a
// phase accumulator over N = 2^LUT_ADDR points per period and writes one
// scaled sample into a downstream FIFO per advancing cycle.
//
// Ports:
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   wavegen_stream_if.slave (conf/en/amp/sel/step/len/full in,
//         wr_en/data/busy/done out, all outputs registered)
//
// Configuration macro:
//   WAVEGEN_SATURATE_EN  defined   -> scaled sample clamped to the signed
//                                     DATA_WIDTH range
//                        undefined -> low DATA_WIDTH bits kept (wrap)
// ---------------------------------------------------------------------------
module wavegen_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int AMP_WIDTH  = 8,
    parameter int LUT_ADDR   = 6
) (
    input  logic            clk,
    input  logic            rst,
    wavegen_stream_if.slave bus
);
    localparam int N      = 2 ** LUT_ADDR;
    localparam int PROD_W = DATA_WIDTH + AMP_WIDTH;
    // Triangle slope: one full swing (2^DATA_WIDTH) over half a period.
    localparam int TRI_SH = DATA_WIDTH - LUT_ADDR + 1;

    localparam logic signed [DATA_WIDTH-1:0] WMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] WMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic signed [DATA_WIDTH-1:0] WNEG = -WMAX;
    // Quarter period offset used to derive cosine from the sine table.
    localparam logic [LUT_ADDR-1:0] QUARTER = {2'b01, {(LUT_ADDR-2){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONFI = 2'd1,
        GEN   = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    // Latched configuration.
    logic signed [AMP_WIDTH-1:0]  amp_r;
    logic        [1:0]            sel_r;
    logic        [LUT_ADDR-1:0]   step_r;
    logic        [15:0]           len_r;

    // Phase accumulator and emitted-sample counter.
    logic        [LUT_ADDR-1:0]   addr_r;
    logic        [15:0]           count_r;

    // Registered outputs.
    logic                         wr_en_r;
    logic signed [DATA_WIDTH-1:0] data_r;
    logic                         busy_r;
    logic                         done_r;

    // FSM control decodes.
    logic                         latch_s;
    logic                         clear_s;
    logic                         advance_s;
    logic                         last_s;

    // Waveform datapath.
    logic signed [DATA_WIDTH-1:0] sine_rom [N];
    logic        [LUT_ADDR-1:0]   cos_addr_s;
    logic signed [DATA_WIDTH-1:0] tri_base_s;
    logic signed [DATA_WIDTH-1:0] wave_s;
    logic signed [DATA_WIDTH-1:0] sample_s;
`ifdef WAVEGEN_SATURATE_EN
    logic signed [PROD_W-1:0]     shifted_s;
`endif

    // One sine table point, round-half-away-from-zero of full-scale sin().
    function automatic logic signed [DATA_WIDTH-1:0] sine_point(input int a);
        real full_scale;
        real x;
        int  r;
        full_scale = (2.0 ** (DATA_WIDTH - 1)) - 1.0;
        x = full_scale * $sin(2.0 * 3.14159265358979323846 * real'(a) / real'(N));
        if (x >= 0.0) begin
            r = $rtoi(x + 0.5);
        end else begin
            r = -$rtoi(0.5 - x);
        end
        return r[DATA_WIDTH-1:0];
    endfunction

    // Elaboration-time sine table; each entry folds to a constant.
    for (genvar g = 0; g < N; g++) begin : g_rom
        assign sine_rom[g] = sine_point(g);
    end

    // Raw waveform value for the current phase address and selected shape.
    always_comb begin
        cos_addr_s = addr_r + QUARTER;
        // Rising ramp: flipping the MSB of a*2^TRI_SH subtracts 2^(DW-1).
        // The falling half is its bitwise complement (max - (a-N/2)*2^TRI_SH).
        tri_base_s = {addr_r[LUT_ADDR-2:0], {TRI_SH{1'b0}}} ^ WMIN;
        case (sel_r)
            2'd0: wave_s = sine_rom[addr_r];
            2'd1: wave_s = sine_rom[cos_addr_s];
            2'd2: begin
                if (addr_r[LUT_ADDR-1]) begin
                    wave_s = ~tri_base_s;
                end else begin
                    wave_s = tri_base_s;
                end
            end
            2'd3: begin
                if (addr_r[LUT_ADDR-1]) begin
                    wave_s = WNEG;
                end else begin
                    wave_s = WMAX;
                end
            end
            default: wave_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Amplitude scaling: full-precision product, floor shift, then reduce.
    always_comb begin
`ifdef WAVEGEN_SATURATE_EN
        shifted_s = (PROD_W'(wave_s) * PROD_W'(amp_r)) >>> (AMP_WIDTH - 1);
        // Overflow when the bits above the sample's sign bit disagree with it.
        if (!shifted_s[PROD_W-1] && (|shifted_s[PROD_W-2:DATA_WIDTH-1])) begin
            sample_s = WMAX;
        end else if (shifted_s[PROD_W-1] && !(&shifted_s[PROD_W-2:DATA_WIDTH-1])) begin
            sample_s = WMIN;
        end else begin
            sample_s = shifted_s[DATA_WIDTH-1:0];
        end
`else
        sample_s = DATA_WIDTH'((PROD_W'(wave_s) * PROD_W'(amp_r)) >>> (AMP_WIDTH - 1));
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.conf_i) begin
                    state_nxt_s = CONFI;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CONFI: state_nxt_s = GEN;
            GEN: begin
                if (bus.conf_i) begin
                    state_nxt_s = CONFI;
                end else if (last_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = GEN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output decodes driving the datapath registers.
    always_comb begin
        latch_s   = 1'b0;
        clear_s   = 1'b0;
        advance_s = 1'b0;
        last_s    = 1'b0;
        case (state_r)
            IDLE: latch_s = bus.conf_i;
            CONFI: clear_s = 1'b1;
            GEN: begin
                // A restart request takes priority over emitting a sample.
                latch_s   = bus.conf_i;
                advance_s = bus.en_i && !bus.full_i && !bus.conf_i;
                if (advance_s && (len_r != 16'd0) && (count_r == (len_r - 16'd1))) begin
                    last_s = 1'b1;
                end else begin
                    last_s = 1'b0;
                end
            end
            default: begin
                latch_s   = 1'b0;
                clear_s   = 1'b0;
                advance_s = 1'b0;
                last_s    = 1'b0;
            end
        endcase
    end

    // Configuration, phase/count and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            amp_r   <= {AMP_WIDTH{1'b0}};
            sel_r   <= 2'd0;
            step_r  <= {LUT_ADDR{1'b0}};
            len_r   <= 16'd0;
            addr_r  <= {LUT_ADDR{1'b0}};
            count_r <= 16'd0;
            wr_en_r <= 1'b0;
            data_r  <= {DATA_WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            if (latch_s) begin
                amp_r  <= bus.amp_i;
                sel_r  <= bus.sel_i;
                step_r <= bus.step_i;
                len_r  <= bus.len_i;
            end
            if (clear_s) begin
                addr_r  <= {LUT_ADDR{1'b0}};
                count_r <= 16'd0;
            end else if (advance_s) begin
                addr_r  <= addr_r + step_r;
                count_r <= count_r + 16'd1;
            end
            if (advance_s) begin
                data_r <= sample_s;
            end
            wr_en_r <= advance_s;
            done_r  <= last_s;
            // Tracks the state register so busy drops with the final sample.
            busy_r  <= (state_nxt_s != IDLE);
        end
    end

    assign bus.wr_en_o = wr_en_r;
    assign bus.data_o  = data_r;
    assign bus.busy_o  = busy_r;
    assign bus.done_o  = done_r;
endmodule

// File: tb/tb_wavegen_stream.sv
// ---------------------------------------------------------------------------
// tb_wavegen_stream
// Self-checking bench for wavegen_stream (default parameters). A reference
// model computes each expected sample from the waveform formulas with real
// and integer arithmetic; directed scenarios cover the documented examples
// and randomized bursts cover stalls, restarts and held configuration.
// Honours WAVEGEN_SATURATE_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_wavegen_stream;
    localparam int DW = 16;
    localparam int AW = 8;
    localparam int LA = 6;
    localparam int N  = 64;
    localparam real PI = 3.14159265358979323846;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wavegen_stream_if #(.DATA_WIDTH(DW), .AMP_WIDTH(AW), .LUT_ADDR(LA)) bus ();

    wavegen_stream #(.DATA_WIDTH(DW), .AMP_WIDTH(AW), .LUT_ADDR(LA)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: phase 0 idle, 1 loading configuration, 2 running.
    int     m_phase;
    int     m_amp, m_sel, m_step, m_len, m_k;
    longint m_data;
    bit     m_wr, m_done;

    // Stimulus configuration applied with the next cycle.
    int cur_amp, cur_sel, cur_step, cur_len;

    longint dut_q[$];
    int     done_cnt;

    task automatic check_val(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic longint sine_ref(input int a);
        real x;
        x = 32767.0 * $sin(2.0 * PI * real'(a) / real'(N));
        if (x >= 0.0) return longint'($rtoi($floor(x + 0.5)));
        return -longint'($rtoi($floor(0.5 - x)));
    endfunction

    function automatic longint wave_ref(input int sel, input int a);
        case (sel)
            0: return sine_ref(a);
            1: return sine_ref((a + N / 4) % N);
            2: return (a < N / 2) ? (-32768 + a * 2048) : (32767 - (a - N / 2) * 2048);
            default: return (a < N / 2) ? 32767 : -32767;
        endcase
    endfunction

    function automatic longint scale_ref(input longint w, input int amp);
        longint p, q;
        p = w * longint'(amp);
        q = (p >= 0) ? (p / 128) : -((-p + 127) / 128);
`ifdef WAVEGEN_SATURATE_EN
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
`else
        q = q & 64'd65535;
        if (q >= 32768) q = q - 65536;
`endif
        return q;
    endfunction

    function automatic longint q_at(input int i);
        if (i < dut_q.size()) return dut_q[i];
        return 64'd999999;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_amp = 0; m_sel = 0; m_step = 0; m_len = 0; m_k = 0;
        m_data = 0; m_wr = 0; m_done = 0;
    endtask

    task automatic model_edge(input bit conf, input bit en, input bit full);
        m_wr = 0;
        m_done = 0;
        if (m_phase == 0) begin
            if (conf) begin
                m_phase = 1;
                m_amp = cur_amp; m_sel = cur_sel; m_step = cur_step; m_len = cur_len;
            end
        end else if (m_phase == 1) begin
            m_phase = 2;
            m_k = 0;
        end else begin
            if (conf) begin
                m_phase = 1;
                m_amp = cur_amp; m_sel = cur_sel; m_step = cur_step; m_len = cur_len;
            end else if (en && !full) begin
                m_wr = 1;
                m_data = scale_ref(wave_ref(m_sel, (m_k * m_step) % N), m_amp);
                m_k++;
                if (m_len != 0 && m_k == m_len) begin
                    m_phase = 0;
                    m_done = 1;
                end
            end
        end
    endtask

    task automatic compare_outputs();
        check_val("wr_en", longint'(bus.wr_en_o), longint'(m_wr));
        check_val("done", longint'(bus.done_o), longint'(m_done));
        check_val("busy", longint'(bus.busy_o), longint'(m_phase != 0));
        check_val("data", longint'(bus.data_o), m_data);
        if (bus.wr_en_o) dut_q.push_back(longint'(bus.data_o));
        if (bus.done_o) done_cnt++;
    endtask

    // Drive one cycle of inputs, let the edge happen, then check.
    task automatic cyc(input bit conf, input bit en, input bit full);
        bus.conf_i = conf;
        bus.en_i   = en;
        bus.full_i = full;
        bus.amp_i  = AW'(cur_amp);
        bus.sel_i  = 2'(cur_sel);
        bus.step_i = LA'(cur_step);
        bus.len_i  = 16'(cur_len);
        @(posedge clk);
        model_edge(conf, en, full);
        #1;
        compare_outputs();
    endtask

    task automatic set_cfg(input int amp, input int sel, input int step, input int len);
        cur_amp = amp; cur_sel = sel; cur_step = step; cur_len = len;
        dut_q.delete();
        done_cnt = 0;
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        set_cfg(0, 0, 0, 0);
        bus.conf_i = 1'b0; bus.en_i = 1'b0; bus.full_i = 1'b0;
        bus.amp_i = '0; bus.sel_i = '0; bus.step_i = '0; bus.len_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_outputs();
        #3 rst = 1'b0;

        // Sine quarter-period burst.
        set_cfg(127, 0, 16, 4);
        cyc(1, 1, 0);
        repeat (8) cyc(0, 1, 0);
        check_val("sine_n", dut_q.size(), 4);
        check_val("sine_s0", q_at(0), 0);
        check_val("sine_s1", q_at(1), 32511);
        check_val("sine_s2", q_at(2), 0);
        check_val("sine_s3", q_at(3), -32512);
        check_val("sine_done", done_cnt, 1);

        // Square with most negative amplitude.
        set_cfg(-128, 3, 32, 2);
        cyc(1, 1, 0);
        repeat (5) cyc(0, 1, 0);
        check_val("sq_s0", q_at(0), -32767);
        check_val("sq_s1", q_at(1), 32767);
        check_val("sq_done", done_cnt, 1);

        // Triangle at a=0 with amp=-128 overflows the sample range.
        set_cfg(-128, 2, 1, 1);
        cyc(1, 1, 0);
        repeat (4) cyc(0, 1, 0);
`ifdef WAVEGEN_SATURATE_EN
        check_val("tri_ovf", q_at(0), 32767);
`else
        check_val("tri_ovf", q_at(0), -32768);
`endif

        // Continuous sine with a FIFO-full stall after the 10th sample.
        set_cfg(127, 0, 1, 0);
        cyc(1, 1, 0);
        guard = 0;
        while (dut_q.size() < 10 && guard < 40) begin cyc(0, 1, 0); guard++; end
        repeat (3) cyc(0, 1, 1);
        guard = 0;
        while (dut_q.size() < 65 && guard < 200) begin cyc(0, 1, 0); guard++; end
        check_val("cont_n", dut_q.size(), 65);
        check_val("cont_s10", q_at(10), scale_ref(wave_ref(0, 10), 127));
        check_val("cont_s64", q_at(64), 0);
        check_val("cont_done", done_cnt, 0);

        // Cosine restarted by conf in the middle of a burst.
        set_cfg(127, 1, 1, 0);
        cyc(1, 1, 0);
        guard = 0;
        while (dut_q.size() < 5 && guard < 40) begin cyc(0, 1, 0); guard++; end
        cyc(1, 1, 0);
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        check_val("cos_restart", q_at(5), 32511);
        check_val("cos_done", done_cnt, 0);

        // Asynchronous reset in the middle of a burst.
        set_cfg(127, 0, 3, 0);
        cyc(1, 1, 0);
        repeat (5) cyc(0, 1, 0);
        #2 rst = 1'b1;
        #1;
        check_val("rst_wr_en", longint'(bus.wr_en_o), 0);
        check_val("rst_busy", longint'(bus.busy_o), 0);
        check_val("rst_done", longint'(bus.done_o), 0);
        check_val("rst_data", longint'(bus.data_o), 0);
        model_reset();
        @(posedge clk);
        #3 rst = 1'b0;
        repeat (5) cyc(0, 1, 0);

        // Randomized bursts with stalls, held conf and occasional restarts.
        for (int b = 0; b < 40; b++) begin
            set_cfg(int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, N - 1)), int'($urandom_range(0, 6)));
            cyc(1, $urandom_range(0, 1) == 1, 1'b0);
            if ($urandom_range(0, 2) == 0) begin
                // Held conf while loading must not re-latch the new amplitude.
                cur_amp = int'($urandom_range(0, 255)) - 128;
                cyc(1, 1'b1, 1'b0);
            end
            for (int c = 0; c < 30; c++) begin
                cyc($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 3) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
